// File: rtl/pipeline_pkg.sv
// Shared pipeline types: opcodes, field slices, fetch packet and FIFO fill state.
package pipeline_pkg;
  localparam int XLEN    = 32;
  localparam int IMEM_AW = 5;

  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_MUL = 8'h02;
  localparam logic [7:0] ALU_CLR = 8'h03;

  localparam int OP_LSB  = 0;
  localparam int OP_MSB  = 7;
  localparam int IMM_LSB = 8;
  localparam int IMM_MSB = 31;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] counter;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_state_t;

  function automatic logic [OP_MSB-OP_LSB:0] instr_op(input logic [XLEN-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [IMM_MSB-IMM_LSB:0] instr_imm(input logic [XLEN-1:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

  function automatic logic op_is_legal(input logic [7:0] op);
    return (op == ALU_ADD) || (op == ALU_MUL) || (op == ALU_CLR);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry fetch packet FIFO with flush; head is read from registered storage, no bypass.
// When empty the head output holds the last popped packet (zero after reset).
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_pkt_t    push_pkt_i,
  input  logic          pop_i,
  output fetch_pkt_t    head_pkt_o,
  output logic          valid_o,
  output logic          full_o,
  output logic [OW-1:0] occupancy_o
);
  fetch_pkt_t    mem_q [DEPTH];
  fetch_pkt_t    last_q, last_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  fill_state_t   fill;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    last_d = last_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i) begin
        head_d = head_q + 1'b1;
        last_d = mem_q[head_q];
      end
      occ_d = occ_q + OW'(push_i) - OW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      last_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      last_q <= last_d;
    end
  end

  // Storage needs no reset: it is only observed once occupancy says it was written.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i && !flush_i) mem_q[tail_q] <= push_pkt_i;
  end

  always_comb begin
    if (occ_q == '0)              fill = FILL_EMPTY;
    else if (occ_q == OW'(DEPTH)) fill = FILL_FULL;
    else                          fill = FILL_PARTIAL;
  end

  assign valid_o     = (fill != FILL_EMPTY);
  assign full_o      = (fill == FILL_FULL);
  assign occupancy_o = occ_q;
  assign head_pkt_o  = valid_o ? mem_q[head_q] : last_q;
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: reads IMEM at fetch_pc, tags with PC and fetch counter, buffers for decode.
// Head visible one cycle after fetch; fetch stalls only when the FIFO is full and not popping.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [IMEM_AW-1:0]     imem_addr,
  input  logic [XLEN-1:0]        imem_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_counter,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] occupancy
);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] fetch_counter_q, fetch_counter_d;
  logic            push, pop, full;
  fetch_pkt_t      push_pkt, head_pkt;

  assign pop  = out_valid & out_ready;
  assign push = !redirect_valid & (!full | pop);

  // The counter is deliberately not touched by redirect so decode sees it only move forward.
  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    fetch_counter_d = fetch_counter_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (push) begin
      fetch_pc_d      = fetch_pc_q + 1'b1;
      fetch_counter_d = fetch_counter_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q      <= '0;
      fetch_counter_q <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      fetch_counter_q <= fetch_counter_d;
    end
  end

  assign imem_addr = fetch_pc_q[IMEM_AW-1:0];
  assign push_pkt  = '{instr: imem_data, pc: fetch_pc_q, counter: fetch_counter_q};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_pkt_i (push_pkt),
    .pop_i      (pop),
    .head_pkt_o (head_pkt),
    .valid_o    (out_valid),
    .full_o     (full),
    .occupancy_o(occupancy)
  );

  assign out_instr   = head_pkt.instr;
  assign out_pc      = head_pkt.pc;
  assign out_counter = head_pkt.counter;
  assign out_illegal = out_valid & !op_is_legal(instr_op(head_pkt.instr));
endmodule
